fft_corr_sequencer: RTL and testbench
=====================================

// Module: fft_corr_sequencer
// PURPOSE
//  Time-shares one FFT core across the three passes of a fast correlation: forward FFT of
//  frame A, forward FFT of frame B, inverse FFT of the spectral product. For each pass it
//  emits one AXIS config word, selects the data source, generates input tlast, and counts
//  input/output beats. Sits between the top-level control FSM and the FFT core + source mux.
// PARAMETERS
//  NFFT      1024   transform length in samples (power of 2, 8..65536)
//  CFG_W     8      config tdata width
//  CFG_FWD   8'hFF  config word for forward pass; inverse pass uses 0
//  TIMEOUT   4*NFFT max cycles per pass without progress before abort (0 disables)
// PORTS
//  aclk         in   1      clock
//  areset       in   1      async reset, active high
//  start        in   1      pulse: begin 3-pass sequence (ignored unless IDLE)
//  busy         out  1      high from accepted start until done/error
//  done         out  1      1-cycle pulse: inverse pass output complete
//  error        out  1      1-cycle pulse: abort (core event or timeout)
//  pass_id      out  2      0=FWD_A 1=FWD_B 2=INV, valid while busy
//  src_sel      out  2      data mux select, equals pass_id during RUN, 3 (none) otherwise
//  cfg_tdata    out  CFG_W  FFT config word
//  cfg_tvalid   out  1      config valid
//  cfg_tready   in   1      config ready from core
//  in_beat      in   1      core data-input handshake (tvalid & tready)
//  in_tlast     out  1      asserted while input beat count == NFFT-1
//  out_beat     in   1      core data-output handshake
//  out_tlast    in   1      core output tlast, qualified by out_beat
//  core_evt     in   1      OR of core tlast_unexpected/tlast_missing events
// BEHAVIOUR
//  Reset: state=IDLE, busy=done=error=cfg_tvalid=in_tlast=0, pass_id=0, src_sel=3, counters 0.
//  States: IDLE -> CFG -> RUN -> DRAIN -> (next pass CFG | FINISH) ; any -> ABORT -> IDLE.
//  IDLE: start=1 -> CFG, pass_id=0, busy=1 next cycle.
//  CFG: cfg_tvalid=1, cfg_tdata=CFG_FWD for pass 0/1, 0 for pass 2; registered, stable
//   until cfg_tvalid&cfg_tready; that cycle -> RUN, in_cnt cleared. One word per pass exactly.
//  RUN: src_sel=pass_id; in_cnt++ per in_beat; in_tlast=(in_cnt==NFFT-1), combinational from
//   registered count; on in_beat with in_cnt==NFFT-1 -> DRAIN, in_cnt=0. Inputs beyond NFFT
//   are not gated here (mux owns tvalid); src_sel=3 outside RUN blocks them.
//  DRAIN: out_cnt++ per out_beat; out_beat&out_tlast -> pass 0/1: pass_id++, CFG;
//   pass 2: FINISH. out_tlast with out_cnt!=NFFT-1 -> ABORT.
//  Output beats may overlap next pass RUN: out_cnt counts in RUN and CFG too; transition
//   out of DRAIN requires both input done and output tlast; tlast seen early is latched.
//  FINISH: done=1 one cycle, busy=0, -> IDLE. Start in same cycle as done is ignored.
//  ABORT: error=1 one cycle, cfg_tvalid=0, src_sel=3, counters cleared, -> IDLE.
//   Causes: core_evt=1 while busy; stall counter reaches TIMEOUT (reset on any handshake).
//  core_evt in IDLE ignored. Reset mid-pass: immediate return to reset values; core must be
//   reset by the same areset (no partial-frame recovery).
//  Counter widths: $clog2(NFFT) bits; stall counter $clog2(TIMEOUT+1).
// STRUCTURE
//  fft_corr_pkg: typedef enum seq_state_t, pass_e {PASS_FWD_A, PASS_FWD_B, PASS_INV},
//   SRC_NONE=2'd3, default CFG_FWD. Sub-module: fft_beat_counter (count, last flag, clear,
//   reused for in_cnt and out_cnt). FSM + config register stay in top.
// TESTING
//  1 NFFT=16, start, cfg_tready=1, in/out_beat always 1 -> 3 cfg words FF,FF,00;
//    in_tlast on beats 15,31,47; done pulse once; busy low next cycle.
//  2 cfg_tready held 0 for 10 cycles -> cfg_tvalid/tdata stable, src_sel=3, no beats counted.
//  3 out_tlast at out_cnt=9 (NFFT=16) -> error pulse, busy=0, src_sel=3, no done.
//  4 core_evt pulse mid-RUN of pass 1 -> error next cycle, IDLE; new start runs clean.
//  5 TIMEOUT=64, in_beat stuck 0 in RUN -> error at 64th idle cycle; any beat resets count.
//  6 areset asserted mid-DRAIN pass 2 -> all outputs at reset values same cycle; start works.

Source files
------------

// File: rtl/fft_corr_pkg.sv
// Shared types and constants for the fast-correlation FFT sequencer.
//  seq_state_t : sequencer FSM states
//  pass_e      : which of the three FFT passes is in progress
//  SRC_NONE    : data-mux select value that routes no source into the core
//  CFG_FWD_DEFAULT : default config word for forward passes
package fft_corr_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_CFG    = 3'd1,
        ST_RUN    = 3'd2,
        ST_DRAIN  = 3'd3,
        ST_FINISH = 3'd4,
        ST_ABORT  = 3'd5
    } seq_state_t;

    typedef enum logic [1:0] {
        PASS_FWD_A = 2'd0,
        PASS_FWD_B = 2'd1,
        PASS_INV   = 2'd2
    } pass_e;

    localparam logic [1:0] SRC_NONE        = 2'd3;
    localparam logic [7:0] CFG_FWD_DEFAULT = 8'hFF;

endpackage

// File: rtl/fft_beat_counter.sv
// Frame beat counter used for both the core input and output streams.
//  aclk   : clock
//  areset : async reset, active high
//  clear  : synchronous clear (wins over inc)
//  inc    : count one beat
//  last   : high while the registered count equals NFFT-1
// NFFT is a power of two, so the count wraps to zero on the last beat.
module fft_beat_counter #(
    parameter int NFFT  = 1024,
    parameter int CNT_W = $clog2(NFFT)
) (
    input  logic aclk,
    input  logic areset,
    input  logic clear,
    input  logic inc,
    output logic last
);

    localparam logic [CNT_W-1:0] LAST_VAL = CNT_W'(NFFT - 1);

    logic [CNT_W-1:0] count_r;

    // Beat count register: clear has priority over increment
    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            count_r <= {CNT_W{1'b0}};
        end else if (clear) begin
            count_r <= {CNT_W{1'b0}};
        end else if (inc) begin
            count_r <= count_r + CNT_W'(1);
        end
    end

    assign last = (count_r == LAST_VAL);

endmodule

// File: rtl/fft_corr_sequencer.sv
// Sequences one FFT core through the three passes of a fast correlation:
// forward FFT of frame A, forward FFT of frame B, inverse FFT of the product.
// Ports:
//  aclk, areset          : clock, async active-high reset
//  start                 : begin a 3-pass sequence (only accepted in IDLE)
//  busy / done / error   : sequence status; done and error are 1-cycle pulses
//  pass_id               : current pass (0=FWD_A 1=FWD_B 2=INV)
//  src_sel               : data mux select, pass_id during RUN else SRC_NONE
//  cfg_tdata/tvalid/tready : one config word per pass to the core
//  in_beat, in_tlast     : core input handshake and generated input tlast
//  out_beat, out_tlast   : core output handshake and its tlast
//  core_evt              : core framing error event
module fft_corr_sequencer
    import fft_corr_pkg::*;
#(
    parameter int               NFFT    = 1024,
    parameter int               CFG_W   = 8,
    parameter logic [CFG_W-1:0] CFG_FWD = CFG_W'(CFG_FWD_DEFAULT),
    parameter int               TIMEOUT = 4 * NFFT
) (
    input  logic             aclk,
    input  logic             areset,
    input  logic             start,
    output logic             busy,
    output logic             done,
    output logic             error,
    output logic [1:0]       pass_id,
    output logic [1:0]       src_sel,
    output logic [CFG_W-1:0] cfg_tdata,
    output logic             cfg_tvalid,
    input  logic             cfg_tready,
    input  logic             in_beat,
    output logic             in_tlast,
    input  logic             out_beat,
    input  logic             out_tlast,
    input  logic             core_evt
);

    localparam int             ST_W       = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [ST_W-1:0] STALL_LAST = ST_W'(TIMEOUT - 1);
    localparam bit             STALL_EN   = (TIMEOUT != 0);

    seq_state_t       state_r;
    pass_e            pass_id_r;
    logic             busy_r, done_r, error_r, cfg_tvalid_r, out_done_r;
    logic [CFG_W-1:0] cfg_tdata_r;
    logic [1:0]       src_sel_r;
    logic [ST_W-1:0]  stall_r;

    logic idle_s, run_s, active_s, cfg_hs_s, hs_s;
    logic in_inc_s, in_last_s, in_done_s, in_clr_s;
    logic out_inc_s, out_last_s, out_tl_s, out_ok_s, out_bad_s, out_clr_s;
    logic stall_hit_s, abort_s, drain_go_s;

    assign idle_s   = (state_r == ST_IDLE);
    assign run_s    = (state_r == ST_RUN);
    assign active_s = (state_r == ST_CFG) || run_s || (state_r == ST_DRAIN);
    assign cfg_hs_s = cfg_tvalid_r & cfg_tready;
    assign hs_s     = cfg_hs_s | in_beat | out_beat;

    assign in_inc_s  = run_s & in_beat;
    assign in_done_s = in_inc_s & in_last_s;
    assign in_clr_s  = idle_s | cfg_hs_s | abort_s;

    // Output beats of a pass may arrive while the input side is still running,
    // so they are counted in every active state and an early tlast is latched.
    assign out_inc_s = active_s & out_beat;
    assign out_tl_s  = out_inc_s & out_tlast;
    assign out_ok_s  = out_tl_s & out_last_s;
    assign out_bad_s = out_tl_s & ~out_last_s;
    assign out_clr_s = idle_s | out_ok_s | abort_s;

    assign stall_hit_s = STALL_EN & ~hs_s & (stall_r == STALL_LAST);
    assign abort_s     = active_s & (core_evt | out_bad_s | stall_hit_s);
    assign drain_go_s  = (state_r == ST_DRAIN) & (out_done_r | out_ok_s);

    fft_beat_counter #(.NFFT(NFFT)) u_in_cnt (
        .aclk   (aclk),
        .areset (areset),
        .clear  (in_clr_s),
        .inc    (in_inc_s),
        .last   (in_last_s)
    );

    fft_beat_counter #(.NFFT(NFFT)) u_out_cnt (
        .aclk   (aclk),
        .areset (areset),
        .clear  (out_clr_s),
        .inc    (out_inc_s),
        .last   (out_last_s)
    );

    // Sequencer FSM with registered status, config and mux-select outputs
    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            state_r      <= ST_IDLE;
            pass_id_r    <= PASS_FWD_A;
            busy_r       <= 1'b0;
            done_r       <= 1'b0;
            error_r      <= 1'b0;
            cfg_tvalid_r <= 1'b0;
            cfg_tdata_r  <= {CFG_W{1'b0}};
            src_sel_r    <= SRC_NONE;
            out_done_r   <= 1'b0;
            stall_r      <= {ST_W{1'b0}};
        end else begin
            done_r  <= 1'b0;
            error_r <= 1'b0;
            if (!active_s || hs_s) begin
                stall_r <= {ST_W{1'b0}};
            end else begin
                stall_r <= stall_r + ST_W'(1);
            end
            if (out_ok_s) begin
                out_done_r <= 1'b1;
            end
            if (abort_s) begin
                state_r      <= ST_ABORT;
                busy_r       <= 1'b0;
                error_r      <= 1'b1;
                cfg_tvalid_r <= 1'b0;
                src_sel_r    <= SRC_NONE;
                out_done_r   <= 1'b0;
                stall_r      <= {ST_W{1'b0}};
            end else begin
                case (state_r)
                    ST_IDLE: begin
                        out_done_r <= 1'b0;
                        if (start) begin
                            state_r      <= ST_CFG;
                            pass_id_r    <= PASS_FWD_A;
                            busy_r       <= 1'b1;
                            cfg_tvalid_r <= 1'b1;
                            cfg_tdata_r  <= CFG_FWD;
                            src_sel_r    <= SRC_NONE;
                        end
                    end
                    ST_CFG: begin
                        if (cfg_hs_s) begin
                            state_r      <= ST_RUN;
                            cfg_tvalid_r <= 1'b0;
                            src_sel_r    <= pass_id_r;
                        end
                    end
                    ST_RUN: begin
                        if (in_done_s) begin
                            state_r   <= ST_DRAIN;
                            src_sel_r <= SRC_NONE;
                        end
                    end
                    ST_DRAIN: begin
                        if (drain_go_s) begin
                            out_done_r <= 1'b0;
                            if (pass_id_r == PASS_INV) begin
                                state_r <= ST_FINISH;
                                busy_r  <= 1'b0;
                                done_r  <= 1'b1;
                            end else begin
                                state_r      <= ST_CFG;
                                pass_id_r    <= (pass_id_r == PASS_FWD_A) ? PASS_FWD_B : PASS_INV;
                                cfg_tvalid_r <= 1'b1;
                                // Only the step into the inverse pass gets the zero word
                                cfg_tdata_r  <= (pass_id_r == PASS_FWD_A) ? CFG_FWD : {CFG_W{1'b0}};
                            end
                        end
                    end
                    ST_FINISH: state_r <= ST_IDLE;
                    ST_ABORT:  state_r <= ST_IDLE;
                    default: begin
                        state_r      <= ST_IDLE;
                        busy_r       <= 1'b0;
                        cfg_tvalid_r <= 1'b0;
                        src_sel_r    <= SRC_NONE;
                    end
                endcase
            end
        end
    end

    assign busy       = busy_r;
    assign done       = done_r;
    assign error      = error_r;
    assign pass_id    = pass_id_r;
    assign src_sel    = src_sel_r;
    assign cfg_tdata  = cfg_tdata_r;
    assign cfg_tvalid = cfg_tvalid_r;
    assign in_tlast   = run_s & in_last_s;

endmodule

// File: tb/tb_fft_corr_sequencer.sv
// Self-checking bench for fft_corr_sequencer with NFFT=16, TIMEOUT=64.
// Inputs change 1 ns after the rising edge; outputs are sampled on the falling edge.
module tb_fft_corr_sequencer;

    logic       aclk = 1'b0;
    logic       areset = 1'b1;
    logic       start = 1'b0;
    logic       busy, done, error, cfg_tvalid, in_tlast;
    logic [1:0] pass_id, src_sel;
    logic [7:0] cfg_tdata;
    logic       cfg_tready = 1'b0;
    logic       in_beat = 1'b0;
    logic       out_beat = 1'b0;
    logic       out_tlast = 1'b0;
    logic       core_evt = 1'b0;

    fft_corr_sequencer #(.NFFT(16), .CFG_W(8), .CFG_FWD(8'hFF), .TIMEOUT(64)) dut (
        .aclk       (aclk),
        .areset     (areset),
        .start      (start),
        .busy       (busy),
        .done       (done),
        .error      (error),
        .pass_id    (pass_id),
        .src_sel    (src_sel),
        .cfg_tdata  (cfg_tdata),
        .cfg_tvalid (cfg_tvalid),
        .cfg_tready (cfg_tready),
        .in_beat    (in_beat),
        .in_tlast   (in_tlast),
        .out_beat   (out_beat),
        .out_tlast  (out_tlast),
        .core_evt   (core_evt)
    );

    always #5 aclk = ~aclk;

    typedef struct {
        int         k;
        logic       busy;
        logic       done;
        logic       err;
        logic       tv;
        logic       tl;
        logic [1:0] src;
        logic       chk_pid;
        logic [1:0] pid;
        logic       chk_dat;
        logic [7:0] dat;
    } vec_t;

    localparam int N_TBL = 14;
    vec_t tbl [N_TBL];

    int n_checks = 0;
    int n_fail = 0;

    int         done_k, err_k, n_done, n_err, n_cfg, n_tl;
    logic       err_busy;
    logic [1:0] err_src;
    logic [7:0] cfg_w [3];
    int         tl_k [3];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic drv(input bit s, input bit tr, input bit ib, input bit ob, input bit ot, input bit ev);
        start      = s;
        cfg_tready = tr;
        in_beat    = ib;
        out_beat   = ob;
        out_tlast  = ot;
        core_evt   = ev;
    endtask

    task automatic clear_obs();
        done_k = -1; err_k = -1; n_done = 0; n_err = 0; n_cfg = 0; n_tl = 0;
        err_busy = 1'b1; err_src = 2'd0;
    endtask

    task automatic observe(input int k);
        if (done) begin
            n_done++;
            if (done_k < 0) done_k = k;
        end
        if (error) begin
            n_err++;
            if (err_k < 0) begin
                err_k = k; err_busy = busy; err_src = src_sel;
            end
        end
        if (cfg_tvalid && cfg_tready) begin
            if (n_cfg < 3) cfg_w[n_cfg] = cfg_tdata;
            n_cfg++;
        end
        if (in_tlast) begin
            if (n_tl < 3) tl_k[n_tl] = k;
            n_tl++;
        end
    endtask

    task automatic do_reset();
        drv(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        areset = 1'b1;
        repeat (3) @(posedge aclk);
        #1 areset = 1'b0;
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_busy"}, busy, 1'b0);
        chk({tag, "_done"}, done, 1'b0);
        chk({tag, "_error"}, error, 1'b0);
        chk({tag, "_cfg_tvalid"}, cfg_tvalid, 1'b0);
        chk({tag, "_in_tlast"}, in_tlast, 1'b0);
        chk({tag, "_pass_id"}, pass_id, 2'd0);
        chk({tag, "_src_sel"}, src_sel, 2'd3);
    endtask

    // Full streaming flow: cfg_tready, in_beat and out_beat high from cycle 1,
    // out_tlast on every 16th output beat; extra start pulses at cycles 30 and 55.
    task automatic run_flow(input int n, input int evt_k, input int rst_k, input bit use_tbl);
        int ti;
        ti = 0;
        clear_obs();
        for (int k = 0; k <= n; k++) begin
            @(posedge aclk); #1;
            drv((k == 0) || (k == 30) || (k == 55), k >= 1, k >= 1, k >= 1,
                (k >= 1) && (k % 16 == 0), k == evt_k);
            if (k == rst_k) begin
                chk("pre_reset_busy", busy, 1'b1);
                chk("pre_reset_src_sel", src_sel, 2'd3);
                chk("pre_reset_pass_id", pass_id, 2'd2);
                areset = 1'b1;
                #1;
                chk_reset_vals("midreset");
            end
            @(negedge aclk);
            observe(k);
            if (use_tbl && ti < N_TBL && tbl[ti].k == k) begin
                chk($sformatf("k%0d_busy", k), busy, tbl[ti].busy);
                chk($sformatf("k%0d_done", k), done, tbl[ti].done);
                chk($sformatf("k%0d_error", k), error, tbl[ti].err);
                chk($sformatf("k%0d_cfg_tvalid", k), cfg_tvalid, tbl[ti].tv);
                chk($sformatf("k%0d_in_tlast", k), in_tlast, tbl[ti].tl);
                chk($sformatf("k%0d_src_sel", k), src_sel, tbl[ti].src);
                if (tbl[ti].chk_pid) chk($sformatf("k%0d_pass_id", k), pass_id, tbl[ti].pid);
                if (tbl[ti].chk_dat) chk($sformatf("k%0d_cfg_tdata", k), cfg_tdata, tbl[ti].dat);
                ti++;
            end
        end
        if (use_tbl) chk("table_entries_visited", ti, N_TBL);
        drv(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    initial begin
        //            k   busy  done  err   tv    tl    src   cpid  pid   cdat  dat
        tbl[0]  = '{0,  1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd3, 1'b0, 2'd0, 1'b0, 8'h00};
        tbl[1]  = '{1,  1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 2'd3, 1'b1, 2'd0, 1'b1, 8'hFF};
        tbl[2]  = '{2,  1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 1'b1, 2'd0, 1'b0, 8'h00};
        tbl[3]  = '{17, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 2'd0, 1'b1, 2'd0, 1'b0, 8'h00};
        tbl[4]  = '{18, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'd3, 1'b1, 2'd0, 1'b0, 8'h00};
        tbl[5]  = '{19, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 2'd3, 1'b1, 2'd1, 1'b1, 8'hFF};
        tbl[6]  = '{20, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'd1, 1'b1, 2'd1, 1'b0, 8'h00};
        tbl[7]  = '{35, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 2'd1, 1'b1, 2'd1, 1'b0, 8'h00};
        tbl[8]  = '{37, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 2'd3, 1'b1, 2'd2, 1'b1, 8'h00};
        tbl[9]  = '{38, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'd2, 1'b1, 2'd2, 1'b0, 8'h00};
        tbl[10] = '{53, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 2'd2, 1'b1, 2'd2, 1'b0, 8'h00};
        tbl[11] = '{54, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'd3, 1'b1, 2'd2, 1'b0, 8'h00};
        tbl[12] = '{55, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 2'd3, 1'b0, 2'd0, 1'b0, 8'h00};
        tbl[13] = '{56, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd3, 1'b0, 2'd0, 1'b0, 8'h00};

        // Reset state
        do_reset();
        @(negedge aclk);
        chk_reset_vals("reset");

        // Full three-pass sequence with continuous beats
        run_flow(60, -1, -1, 1'b1);
        chk("t1_done_count", n_done, 1);
        chk("t1_done_cycle", done_k, 55);
        chk("t1_error_count", n_err, 0);
        chk("t1_cfg_count", n_cfg, 3);
        chk("t1_cfg_word0", cfg_w[0], 8'hFF);
        chk("t1_cfg_word1", cfg_w[1], 8'hFF);
        chk("t1_cfg_word2", cfg_w[2], 8'h00);
        chk("t1_tlast_count", n_tl, 3);
        chk("t1_tlast0_cycle", tl_k[0], 17);
        chk("t1_tlast1_cycle", tl_k[1], 35);
        chk("t1_tlast2_cycle", tl_k[2], 53);

        // Config back-pressure: word held stable, no input beats counted
        do_reset();
        clear_obs();
        for (int k = 0; k <= 30; k++) begin
            @(posedge aclk); #1;
            drv(k == 0, k == 11, k >= 1, 1'b0, 1'b0, 1'b0);
            @(negedge aclk);
            observe(k);
            if (k >= 1 && k <= 10) begin
                chk($sformatf("t2_k%0d_cfg_tvalid", k), cfg_tvalid, 1'b1);
                chk($sformatf("t2_k%0d_cfg_tdata", k), cfg_tdata, 8'hFF);
                chk($sformatf("t2_k%0d_src_sel", k), src_sel, 2'd3);
            end
        end
        chk("t2_cfg_count", n_cfg, 1);
        chk("t2_first_tlast_cycle", (n_tl > 0) ? tl_k[0] : -1, 27);
        chk("t2_error_count", n_err, 0);

        // Output tlast at the wrong beat count aborts
        do_reset();
        clear_obs();
        for (int k = 0; k <= 15; k++) begin
            @(posedge aclk); #1;
            drv(k == 0, 1'b1, 1'b0, (k >= 1) && (k <= 10), k == 10, 1'b0);
            @(negedge aclk);
            observe(k);
        end
        chk("t3_error_cycle", err_k, 11);
        chk("t3_error_count", n_err, 1);
        chk("t3_busy_at_error", err_busy, 1'b0);
        chk("t3_src_at_error", err_src, 2'd3);
        chk("t3_done_count", n_done, 0);

        // core_evt during pass 1 run, then IDLE ignores core_evt, then a clean run
        do_reset();
        run_flow(29, 25, -1, 1'b0);
        chk("t4_error_cycle", err_k, 26);
        chk("t4_error_count", n_err, 1);
        chk("t4_busy_at_error", err_busy, 1'b0);
        chk("t4_src_at_error", err_src, 2'd3);
        chk("t4_done_count", n_done, 0);
        clear_obs();
        for (int k = 0; k < 3; k++) begin
            @(posedge aclk); #1;
            drv(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
            @(negedge aclk);
            observe(k);
        end
        chk("t4_idle_evt_errors", n_err, 0);
        chk("t4_idle_evt_busy", busy, 1'b0);
        run_flow(60, -1, -1, 1'b1);
        chk("t4_rerun_done_cycle", done_k, 55);
        chk("t4_rerun_error_count", n_err, 0);

        // Stall timeout in RUN
        do_reset();
        clear_obs();
        for (int k = 0; k <= 70; k++) begin
            @(posedge aclk); #1;
            drv(k == 0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
            @(negedge aclk);
            observe(k);
            if (k == 65) chk("t5a_busy_before_timeout", busy, 1'b1);
        end
        chk("t5a_error_cycle", err_k, 66);
        chk("t5a_error_count", n_err, 1);

        // A single input beat restarts the stall count
        do_reset();
        clear_obs();
        for (int k = 0; k <= 100; k++) begin
            @(posedge aclk); #1;
            drv(k == 0, 1'b1, k == 30, 1'b0, 1'b0, 1'b0);
            @(negedge aclk);
            observe(k);
        end
        chk("t5b_error_cycle", err_k, 95);
        chk("t5b_error_count", n_err, 1);

        // Async reset in the pass-2 drain cycle, then a clean run
        do_reset();
        run_flow(54, -1, 54, 1'b0);
        repeat (2) @(posedge aclk);
        #1 areset = 1'b0;
        run_flow(60, -1, -1, 1'b1);
        chk("t6_rerun_done_cycle", done_k, 55);
        chk("t6_rerun_error_count", n_err, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
